// File: rtl/logic_reduce_unit.sv
// Handshaked multi-mode bitwise reducer: folds a packet of WIDTH-bit words with AND/OR/XOR (optionally inverted).
// Optional feature: define LRU_COUNT_EN to expose out_count (words in the reduced packet).
module logic_reduce_unit #(
    parameter int WIDTH   = 8,
    parameter int MAX_OPS = 16,
    localparam int CW     = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef LRU_COUNT_EN
    output logic [CW-1:0]    out_count,
`endif
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Base gate of a mode: 0/3 AND, 2/5 XOR, everything else (1/4/6/7) OR.
    function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] m,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (m)
            3'd0, 3'd3: apply_op = a & b;
            3'd2, 3'd5: apply_op = a ^ b;
            default:    apply_op = a | b;
        endcase
    endfunction

    function automatic logic is_inverting(input logic [2:0] m);
        is_inverting = (m >= 3'd3);
    endfunction

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_mode;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
`ifdef LRU_COUNT_EN
    logic [CW-1:0]    r_out_count;
`endif

    logic [2:0]       w_op_mode;
    logic [WIDTH-1:0] w_next_acc;
    logic [CW-1:0]    w_next_cnt;
    logic             w_last_hit;
    logic [WIDTH-1:0] w_result;

    assign in_ready  = (r_state != ST_HOLD);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
`ifdef LRU_COUNT_EN
    assign out_count = r_out_count;
`endif

    // Accumulator, word count and termination for a beat in the current state
    always_comb begin
        w_op_mode  = r_mode;
        w_next_acc = r_acc;
        w_next_cnt = r_cnt;
        w_last_hit = 1'b0;
        if (r_state == ST_IDLE) begin
            // First word: mode is taken live, it is only latched at this beat.
            w_op_mode  = mode;
            w_next_acc = in_data;
            w_next_cnt = CW'(1);
            w_last_hit = in_last || (MAX_OPS == 32'sd1);
        end else begin
            w_next_acc = apply_op(r_mode, r_acc, in_data);
            w_next_cnt = r_cnt + CW'(1);
            w_last_hit = in_last || (w_next_cnt == CW'(MAX_OPS));
        end
        w_result = is_inverting(w_op_mode) ? ~w_next_acc : w_next_acc;
    end

    // Packet FSM with registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_mode      <= 3'd4;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
`ifdef LRU_COUNT_EN
            r_out_count <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_ACCUM: begin
                    if (in_valid) begin
                        if (r_state == ST_IDLE) begin
                            r_mode <= mode;
                        end else begin
                            r_mode <= r_mode;
                        end
                        r_acc <= w_next_acc;
                        r_cnt <= w_next_cnt;
                        if (w_last_hit) begin
                            r_state     <= ST_HOLD;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_result;
`ifdef LRU_COUNT_EN
                            r_out_count <= w_next_cnt;
`endif
                        end else begin
                            r_state <= ST_ACCUM;
                        end
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_reduce_unit.sv
// Self-checking bench for logic_reduce_unit (WIDTH=4, MAX_OPS=4): vector table, corner sequences, random packets.
module tb_logic_reduce_unit;

    localparam int WIDTH   = 4;
    localparam int MAX_OPS = 4;
    localparam int CW      = $clog2(MAX_OPS + 1);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic [2:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef LRU_COUNT_EN
    logic [CW-1:0]    out_count;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic_reduce_unit #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef LRU_COUNT_EN
        .out_count (out_count),
`endif
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  m0;
        logic [2:0]  mr;
        int          n;
        logic [15:0] w;
        logic [3:0]  ed;
        int          ec;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: per bit, count ones across the packet and apply the gate rule.
    function automatic logic [3:0] ref_model(input logic [2:0] m, input logic [3:0] ws [4], input int n);
        logic [3:0] r;
        for (int b = 0; b < 4; b++) begin
            int ones;
            ones = 0;
            for (int k = 0; k < n; k++) ones += ws[k][b];
            case (m)
                3'd0, 3'd3: r[b] = (ones == n);
                3'd2, 3'd5: r[b] = (ones % 2 == 1);
                default:    r[b] = (ones > 0);
            endcase
        end
        if (m >= 3'd3) r = ~r;
        return r;
    endfunction

    task automatic drive_word(input logic [3:0] d, input logic l, input logic [2:0] m);
        int waited;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        mode     = m;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL in_ready_timeout: in_ready stuck at 0");
        end
        @(posedge clk);
    endtask

    task automatic end_words();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called at the negedge right after the final beat.
    task automatic expect_result(input string tag, input logic [3:0] ed, input int ec, input int stall);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"}, {28'd0, out_data}, {28'd0, ed});
        chk({tag, "_inready_hold"}, {31'd0, in_ready}, 32'd0);
`ifdef LRU_COUNT_EN
        chk({tag, "_count"}, {29'd0, out_count}, ec);
`else
        if (ec < 0) $display("unexpected count argument %0d", ec);
`endif
        out_ready = (stall == 0);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_stall_data"}, {28'd0, out_data}, {28'd0, ed});
            chk({tag, "_stall_inready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_done_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_done_inready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_data_kept"}, {28'd0, out_data}, {28'd0, ed});
    endtask

    initial begin
        logic [15:0] wv;
        logic [3:0]  ws [4];
        logic [2:0]  m0;
        int          n;
        logic        lst;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        in_last   = 1'b0;
        mode      = 3'd0;
        out_ready = 1'b1;

        tbl[0] = '{3'd4, 3'd4, 1, 16'h0000, 4'b1111, 1};
        tbl[1] = '{3'd4, 3'd4, 3, 16'h0021, 4'b1100, 3};
        tbl[2] = '{3'd3, 3'd1, 2, 16'h00AC, 4'b0111, 2};
        tbl[3] = '{3'd2, 3'd2, 2, 16'h006A, 4'b1100, 2};
        tbl[4] = '{3'd5, 3'd5, 3, 16'h035F, 4'b0110, 3};
        tbl[5] = '{3'd7, 3'd0, 2, 16'h0000, 4'b1111, 2};
        tbl[6] = '{3'd6, 3'd6, 1, 16'h0008, 4'b0111, 1};
        tbl[7] = '{3'd0, 3'd0, 4, 16'hB7EF, 4'b0010, 4};

        repeat (2) @(negedge clk);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_data", {28'd0, out_data}, 32'd0);
        chk("reset_inready", {31'd0, in_ready}, 32'd1);
`ifdef LRU_COUNT_EN
        chk("reset_count", {29'd0, out_count}, 32'd0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            wv = tbl[i].w;
            for (int k = 0; k < tbl[i].n; k++)
                drive_word(wv[4*k +: 4], k == tbl[i].n - 1, (k == 0) ? tbl[i].m0 : tbl[i].mr);
            end_words();
            expect_result($sformatf("vec%0d", i), tbl[i].ed, tbl[i].ec, 0);
        end

        // Forced last at MAX_OPS; the following word opens a fresh NOR packet.
        for (int k = 0; k < 4; k++) drive_word(4'b1111, 1'b0, 3'd0);
        end_words();
        expect_result("forced_last", 4'b1111, 4, 0);
        drive_word(4'b1111, 1'b1, 3'd4);
        end_words();
        expect_result("after_forced", 4'b0000, 1, 0);

        // XOR result held through a 3-cycle consumer stall.
        drive_word(4'b1010, 1'b0, 3'd2);
        drive_word(4'b0110, 1'b1, 3'd2);
        end_words();
        expect_result("stall", 4'b1100, 2, 3);

        // Reset in the middle of a packet discards it.
        drive_word(4'b0001, 1'b0, 3'd1);
        drive_word(4'b0100, 1'b0, 3'd1);
        end_words();
        chk("accum_no_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_data", {28'd0, out_data}, 32'd0);
        chk("midrst_inready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        drive_word(4'b1000, 1'b1, 3'd1);
        end_words();
        expect_result("post_rst", 4'b1000, 1, 0);

        for (int p = 0; p < 60; p++) begin
            n   = $urandom_range(1, 4);
            m0  = 3'($urandom_range(0, 7));
            lst = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) ws[k] = 4'($urandom_range(0, 15));
            for (int k = 0; k < n; k++)
                drive_word(ws[k], (k == n - 1) ? lst : 1'b0, (k == 0) ? m0 : 3'($urandom_range(0, 7)));
            end_words();
            expect_result($sformatf("rand%0d", p), ref_model(m0, ws, n), n, $urandom_range(0, 2));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
